// File: rtl/program_loader.sv
// Byte-stream program loader: takes a length header, a run of big-endian instruction words
// and a trailing XOR checksum, and writes the words into instruction memory.
module program_loader #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 28,
  parameter int MAX_WORDS   = 256
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iStart,
  input  logic [7:0]             iByte,
  input  logic                   iByteValid,
  output logic                   oByteReady,
  output logic                   oWriteEnable,
  output logic [ADDR_WIDTH-1:0]  oWriteAddress,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  output logic                   oCpuReset,
  output logic                   oDone,
  output logic                   oError,
  output logic [1:0]             oErrorCode,
  output logic [ADDR_WIDTH-1:0]  oWordCount
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_LOAD, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t                  state_q;
  logic [15:0]             len_q;
  logic [1:0]              bidx_q;
  logic [19:0]             sh_q;      // {b0[3:0], b1, b2} collected before the last byte
  logic [7:0]              csum_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    rdy_q, we_q, cpurst_q, done_q, err_q;
  logic [1:0]              ecode_q;
  logic [INSTR_WIDTH-1:0]  instr_q;

  logic                    take;
  logic [15:0]             len_d;
  logic [ADDR_WIDTH-1:0]   idx_d;

  assign take  = iByteValid & rdy_q;
  assign len_d = {len_q[15:8], iByte};
  assign idx_d = idx_q + 1'b1;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      bidx_q   <= '0;
      sh_q     <= '0;
      csum_q   <= '0;
      idx_q    <= '0;
      rdy_q    <= 1'b0;
      we_q     <= 1'b0;
      instr_q  <= '0;
      cpurst_q <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ecode_q  <= 2'b00;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (iStart) begin
            state_q  <= S_HDR_HI;
            rdy_q    <= 1'b1;
            idx_q    <= '0;
            csum_q   <= '0;
            err_q    <= 1'b0;
            ecode_q  <= 2'b00;
            done_q   <= 1'b0;
            cpurst_q <= 1'b1;
          end
        end
        S_HDR_HI: begin
          if (take) begin
            len_q[15:8] <= iByte;
            state_q     <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (take) begin
            len_q <= len_d;
            if (len_d == 16'd0 || len_d > MAX_N) begin
              state_q <= S_ERROR;
              rdy_q   <= 1'b0;
              err_q   <= 1'b1;
              ecode_q <= 2'b01;
            end else begin
              state_q <= S_LOAD;
              bidx_q  <= 2'd0;
            end
          end
        end
        S_LOAD: begin
          if (take) begin
            csum_q <= csum_q ^ iByte;
            bidx_q <= bidx_q + 2'd1;
            case (bidx_q)
              2'd0: sh_q <= {16'd0, iByte[3:0]};
              2'd3: begin
                instr_q <= INSTR_WIDTH'({sh_q, iByte});
                we_q    <= 1'b1;
                rdy_q   <= 1'b0;
                state_q <= S_WRITE;
              end
              default: sh_q <= {sh_q[11:0], iByte};
            endcase
          end
        end
        S_WRITE: begin
          // Write strobe is live this cycle with address = idx_q; advance afterwards.
          idx_q <= idx_d;
          rdy_q <= 1'b1;
          state_q <= (16'(idx_d) == len_q) ? S_CHECK : S_LOAD;
        end
        S_CHECK: begin
          if (take) begin
            rdy_q <= 1'b0;
            if (iByte == csum_q) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              cpurst_q <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
              ecode_q <= 2'b10;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oByteReady    = rdy_q;
  assign oWriteEnable  = we_q;
  assign oWriteAddress = idx_q;
  assign oInstruction  = instr_q;
  assign oCpuReset     = cpurst_q;
  assign oDone         = done_q;
  assign oError        = err_q;
  assign oErrorCode    = ecode_q;
  assign oWordCount    = idx_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: header/word/checksum streams with hand-computed results.
module tb_program_loader;

  logic        Clock, Reset, iStart, iByteValid;
  logic [7:0]  iByte;
  logic        oByteReady, oWriteEnable, oCpuReset, oDone, oError;
  logic [15:0] oWriteAddress, oWordCount;
  logic [27:0] oInstruction;
  logic [1:0]  oErrorCode;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] wa_log[$];
  logic [27:0] wd_log[$];
  int          rdy_bad = 0;

  logic [7:0] img1 [7];
  logic [7:0] img3 [15];
  logic [7:0] imgr [10];
  logic [27:0] exp3 [3];

  program_loader dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iByte(iByte),
    .iByteValid(iByteValid), .oByteReady(oByteReady), .oWriteEnable(oWriteEnable),
    .oWriteAddress(oWriteAddress), .oInstruction(oInstruction), .oCpuReset(oCpuReset),
    .oDone(oDone), .oError(oError), .oErrorCode(oErrorCode), .oWordCount(oWordCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (oWriteEnable) begin
      wa_log.push_back(oWriteAddress);
      wd_log.push_back(oInstruction);
      if (oByteReady) rdy_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [7:0] b, input bit stall);
    bit acc = 0;
    int t = 0;
    while (!acc && t < 100) begin
      iByte = b;
      iByteValid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = iByteValid && oByteReady;
      @(negedge Clock);
      t++;
    end
    iByteValid = 1'b0;
    if (!acc) check("byte_timeout", 32'(acc), 32'd1);
  endtask

  task automatic start();
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
  endtask

  task automatic clear_log();
    wa_log.delete();
    wd_log.delete();
    rdy_bad = 0;
  endtask

  initial begin
    img1 = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h00, 8'h07, 8'h06};
    img3 = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01,
             8'hF0, 8'h0F, 8'hA5, 8'h5A, 8'h80};
    imgr = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00};
    exp3 = '{28'h2345678, 28'hBCDEF01, 28'h00FA55A};
    Reset = 1'b0; iStart = 1'b0; iByteValid = 1'b0; iByte = 8'h00;

    // reset values
    #12;
    check("rst_ready", 32'(oByteReady), 32'd0);
    check("rst_we", 32'(oWriteEnable), 32'd0);
    check("rst_addr", 32'(oWriteAddress), 32'd0);
    check("rst_instr", 32'(oInstruction), 32'd0);
    check("rst_cpurst", 32'(oCpuReset), 32'd1);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_err", 32'(oError), 32'd0);
    check("rst_code", 32'(oErrorCode), 32'd0);
    check("rst_wc", 32'(oWordCount), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check("idle_ignores_bytes", 32'(oByteReady), 32'd0);

    // single-word load
    clear_log();
    start();
    check("start_ready", 32'(oByteReady), 32'd1);
    for (int i = 0; i < 6; i++) send(img1[i], 1'b0);
    check("w1_we", 32'(oWriteEnable), 32'd1);
    check("w1_addr", 32'(oWriteAddress), 32'd0);
    check("w1_data", 32'(oInstruction), 32'h4050007);
    check("w1_ready_low", 32'(oByteReady), 32'd0);
    send(img1[6], 1'b0);
    check("w1_done", 32'(oDone), 32'd1);
    check("w1_cpurst", 32'(oCpuReset), 32'd0);
    check("w1_wc", 32'(oWordCount), 32'd1);
    check("w1_nwrites", 32'(wa_log.size()), 32'd1);

    // asynchronous reset mid-cycle, no clock edge in between
    #2 Reset = 1'b0;
    #1;
    check("async_done", 32'(oDone), 32'd0);
    check("async_cpurst", 32'(oCpuReset), 32'd1);
    check("async_wc", 32'(oWordCount), 32'd0);
    check("async_instr", 32'(oInstruction), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    // three words with random valid stalls
    clear_log();
    start();
    for (int i = 0; i < 15; i++) send(img3[i], 1'b1);
    check("bp_done", 32'(oDone), 32'd1);
    check("bp_wc", 32'(oWordCount), 32'd3);
    check("bp_nwrites", 32'(wa_log.size()), 32'd3);
    check("bp_ready_in_write", 32'(rdy_bad), 32'd0);
    for (int i = 0; i < 3 && i < wa_log.size(); i++) begin
      check($sformatf("bp_addr%0d", i), 32'(wa_log[i]), 32'(i));
      check($sformatf("bp_data%0d", i), 32'(wd_log[i]), 32'(exp3[i]));
    end

    // bad length: zero, then 257
    clear_log();
    start();
    check("start_clears_done", 32'(oDone), 32'd0);
    send(8'h00, 1'b0); send(8'h00, 1'b0);
    check("len0_err", 32'(oError), 32'd1);
    check("len0_code", 32'(oErrorCode), 32'd1);
    check("len0_cpurst", 32'(oCpuReset), 32'd1);
    check("len0_ready", 32'(oByteReady), 32'd0);
    start();
    check("start_clears_err", 32'(oError), 32'd0);
    send(8'h01, 1'b0); send(8'h01, 1'b0);
    check("len257_err", 32'(oError), 32'd1);
    check("len257_code", 32'(oErrorCode), 32'd1);
    check("len257_cpurst", 32'(oCpuReset), 32'd1);
    repeat (3) @(negedge Clock);
    check("len_nwrites", 32'(wa_log.size()), 32'd0);

    // checksum mismatch, then recovery
    clear_log();
    start();
    for (int i = 0; i < 6; i++) send(img1[i], 1'b0);
    send(8'h07, 1'b0);
    check("cs_err", 32'(oError), 32'd1);
    check("cs_code", 32'(oErrorCode), 32'd2);
    check("cs_done", 32'(oDone), 32'd0);
    check("cs_cpurst", 32'(oCpuReset), 32'd1);
    check("cs_nwrites", 32'(wa_log.size()), 32'd1);
    if (wa_log.size() > 0) check("cs_addr", 32'(wa_log[0]), 32'd0);
    start();
    for (int i = 0; i < 7; i++) send(img1[i], 1'b0);
    check("cs_retry_done", 32'(oDone), 32'd1);
    check("cs_retry_code", 32'(oErrorCode), 32'd0);

    // reset after two bytes of word 1
    clear_log();
    start();
    for (int i = 0; i < 8; i++) send(imgr[i], 1'b0);
    #2 Reset = 1'b0;
    #1;
    check("mid_cpurst", 32'(oCpuReset), 32'd1);
    check("mid_ready", 32'(oByteReady), 32'd0);
    check("mid_we", 32'(oWriteEnable), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    iByteValid = 1'b1; iByte = 8'h77;
    repeat (6) @(negedge Clock);
    iByteValid = 1'b0;
    check("mid_nwrites", 32'(wa_log.size()), 32'd1);
    check("mid_cpurst_hold", 32'(oCpuReset), 32'd1);
    check("mid_idle_ready", 32'(oByteReady), 32'd0);
    start();
    for (int i = 0; i < 7; i++) send(img1[i], 1'b0);
    check("mid_reload_done", 32'(oDone), 32'd1);
    check("mid_reload_wc", 32'(oWordCount), 32'd1);
    check("mid_reload_nwrites", 32'(wa_log.size()), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
